// File: rtl/ipf_psum_accum_pkg.sv
// Shared lane geometry, FSM state encoding and the per-lane product adder
// used by the IPF partial-sum accumulator.
package ipf_psum_accum_pkg;

   localparam int NUM_LANES = 4;
   localparam int PROD_W    = 4;
   localparam int BEAT_W    = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // One lane carries two unsigned 4-bit products; their sum fits 5 bits (max 18).
   function automatic logic [BEAT_W-1:0] beat_sum(input logic [2*PROD_W-1:0] lane);
      return BEAT_W'(lane[2*PROD_W-1:PROD_W]) + BEAT_W'(lane[PROD_W-1:0]);
   endfunction

endpackage

// File: rtl/ipf_psum_accum_fifo.sv
// Two-entry synchronous FIFO holding completed windows ({lane sums, last}).
// A push while full is accepted only if the head is popped in the same cycle.
module ipf_psum_accum_fifo #(
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             rd_q;
   logic             wr_q;
   logic [1:0]       cnt_q;
   logic [1:0]       cnt_d;
   logic             do_pop;
   logic             do_push;

   assign full    = (cnt_q == 2'd2);
   assign empty   = (cnt_q == 2'd0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem_q[rd_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (do_push) wr_q <= ~wr_q;
         if (do_pop)  rd_q <= ~rd_q;
         cnt_q <= cnt_d;
      end
   end

   // Storage is never read while empty, so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data;
   end

endmodule

// File: rtl/ipf_psum_accum.sv
// Accumulates the four IPF product lanes over ACC_LEN valid beats, saturating per lane,
// and queues completed windows (plus a flushed partial on finish) for a ready/valid consumer.
module ipf_psum_accum
   import ipf_psum_accum_pkg::*;
#(
   parameter int ACC_LEN = 3,
   parameter int ACC_W   = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              res,
   input  logic                     res_valid,
   input  logic                     finish_in,
   output logic [NUM_LANES*ACC_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     ovf_err,
   output logic                     done
);

   localparam int CNT_W = $clog2(ACC_LEN + 1);
   localparam int SUM_W = ACC_W + 1;
   localparam int ENT_W = NUM_LANES * ACC_W + 1;

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [BEAT_W-1:0] b);
      logic [SUM_W-1:0] s;
      s = {1'b0, a} + SUM_W'(b);
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   state_e                              state_q, state_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic [NUM_LANES-1:0][ACC_W-1:0]     acc_q, acc_d;
   logic [NUM_LANES-1:0][ACC_W-1:0]     sum;
   logic                                ovf_q;
   logic                                done_q;
   logic                                beat_ok;
   logic                                win_close;
   logic                                push;
   logic [ENT_W-1:0]                    push_data;
   logic                                pop;
   logic [ENT_W-1:0]                    head;
   logic                                full;
   logic                                empty;

   // First beat of a window starts from zero rather than the stale accumulator.
   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         sum[k] = sat_add((cnt_q == '0) ? '0 : acc_q[k],
                          beat_sum(res[2*PROD_W*k +: 2*PROD_W]));
      end
   end

   assign beat_ok   = res_valid & ((state_q == IDLE) | (state_q == ACC));
   assign win_close = (cnt_q == CNT_W'(ACC_LEN - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      push      = 1'b0;
      push_data = {sum, 1'b0};
      case (state_q)
         IDLE, ACC: begin
            if (beat_ok) begin
               acc_d = sum;
               if (win_close) begin
                  push  = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (state_q == IDLE) state_d = ACC;
            end
            if (finish_in) state_d = FLUSH;
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end else if (~full | pop) begin
               // The partial must never be dropped, so it waits for buffer room.
               push      = 1'b1;
               push_data = {acc_q, 1'b1};
               cnt_d     = '0;
               state_d   = DONE;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_q | (push & full & ~pop);
         done_q  <= (state_q == DONE) & empty;
      end
   end

   ipf_psum_accum_fifo #(.WIDTH(ENT_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign pop       = out_ready & ~empty;
   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : head[ENT_W-1:1];
   assign out_last  = ~empty & head[0];
   assign ovf_err   = ovf_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ipf_psum_accum.sv
// Directed bench for ipf_psum_accum: a default instance (ACC_W=9) plus a narrow
// instance (ACC_W=5) for the saturation case.
module tb_ipf_psum_accum;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] res;
   logic        res_valid, finish_in, out_ready;
   logic [35:0] out_data;
   logic        out_valid, out_last, ovf_err, done;

   logic [31:0] res5;
   logic        res_valid5, finish5, out_ready5;
   logic [19:0] out_data5;
   logic        out_valid5, out_last5, ovf5, done5;

   int vecs = 0;
   int errs = 0;

   localparam logic [35:0] D6 = {4{9'd6}};
   localparam logic [35:0] D9 = {4{9'd9}};

   ipf_psum_accum #(.ACC_LEN(3), .ACC_W(9)) dut (
      .clk(clk), .rst(rst), .res(res), .res_valid(res_valid), .finish_in(finish_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .ovf_err(ovf_err), .done(done)
   );

   ipf_psum_accum #(.ACC_LEN(3), .ACC_W(5)) dut5 (
      .clk(clk), .rst(rst), .res(res5), .res_valid(res_valid5), .finish_in(finish5),
      .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
      .out_last(out_last5), .ovf_err(ovf5), .done(done5)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] r);
      res       = r;
      res_valid = 1'b1;
      step;
      res_valid = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      res = '0; res_valid = 1'b0; finish_in = 1'b0; out_ready = 1'b0;
      res5 = '0; res_valid5 = 1'b0; finish5 = 1'b0; out_ready5 = 1'b0;
      step;
      step;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      vecs++;
      if ({out_valid, out_last, ovf_err, done, out_data} !== 40'd0) begin
         errs++;
         $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_last, ovf_err, done, out_data});
      end
      vecs++;
      if ({out_valid5, out_last5, ovf5, done5, out_data5} !== 24'd0) begin
         errs++;
         $display("FAIL reset_outputs_w5: got %h expected 0", {out_valid5, out_last5, ovf5, done5, out_data5});
      end
   endtask

   task automatic test_single_window;
      do_reset;
      out_ready = 1'b1;
      beat(32'h1111_1111);
      beat(32'h1111_1111);
      vecs++;
      if (out_valid !== 1'b0) begin
         errs++; $display("FAIL single_early_valid: got %b expected 0", out_valid);
      end
      beat(32'h1111_1111);
      vecs++;
      if (out_valid !== 1'b1) begin
         errs++; $display("FAIL single_latency: got %b expected 1", out_valid);
      end
      vecs++;
      if (out_data !== D6) begin
         errs++; $display("FAIL single_data: got %h expected %h", out_data, D6);
      end
      vecs++;
      if (out_last !== 1'b0) begin
         errs++; $display("FAIL single_last: got %b expected 0", out_last);
      end
      step;
      vecs++;
      if (out_valid !== 1'b0 || out_data !== 36'd0) begin
         errs++; $display("FAIL single_popped: got valid=%b data=%h expected 0/0", out_valid, out_data);
      end
   endtask

   task automatic test_saturation;
      do_reset;
      out_ready5 = 1'b1;
      res5 = 32'h9999_9999;
      res_valid5 = 1'b1;
      step; step; step;
      res_valid5 = 1'b0;
      vecs++;
      if (out_valid5 !== 1'b1 || out_data5 !== 20'hF_FFFF) begin
         errs++; $display("FAIL sat_data: got valid=%b data=%h expected 1/fffff", out_valid5, out_data5);
      end
      vecs++;
      if (ovf5 !== 1'b0) begin
         errs++; $display("FAIL sat_ovf: got %b expected 0", ovf5);
      end
   endtask

   task automatic test_overflow;
      do_reset;
      for (int i = 0; i < 9; i++) beat(32'h1111_1111);
      vecs++;
      if (ovf_err !== 1'b1) begin
         errs++; $display("FAIL ovf_set: got %b expected 1", ovf_err);
      end
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D6) begin
         errs++; $display("FAIL ovf_head: got valid=%b data=%h expected 1/%h", out_valid, out_data, D6);
      end
      out_ready = 1'b1;
      step;
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D6) begin
         errs++; $display("FAIL ovf_second: got valid=%b data=%h expected 1/%h", out_valid, out_data, D6);
      end
      step;
      vecs++;
      if (out_valid !== 1'b0 || ovf_err !== 1'b1) begin
         errs++; $display("FAIL ovf_drained: got valid=%b ovf=%b expected 0/1", out_valid, ovf_err);
      end
   endtask

   task automatic test_flush_partial;
      int n;
      do_reset;
      beat(32'h2121_2121);
      beat(32'h2121_2121);
      finish_in = 1'b1;
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin step; n++; end
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D6) begin
         errs++; $display("FAIL flush_data: got valid=%b data=%h expected 1/%h", out_valid, out_data, D6);
      end
      vecs++;
      if (out_last !== 1'b1) begin
         errs++; $display("FAIL flush_last: got %b expected 1", out_last);
      end
      step;
      vecs++;
      if (done !== 1'b0) begin
         errs++; $display("FAIL flush_done_early: got %b expected 0", done);
      end
      out_ready = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 10) begin step; n++; end
      vecs++;
      if (done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         errs++; $display("FAIL flush_done: got done=%b valid=%b last=%b expected 1/0/0", done, out_valid, out_last);
      end
   endtask

   task automatic test_finish_on_close;
      int n;
      do_reset;
      beat(32'h1111_1111);
      beat(32'h1111_1111);
      res = 32'h1111_1111; res_valid = 1'b1; finish_in = 1'b1;
      step;
      res_valid = 1'b0;
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D6 || out_last !== 1'b0) begin
         errs++; $display("FAIL fclose_entry: got valid=%b data=%h last=%b expected 1/%h/0", out_valid, out_data, out_last, D6);
      end
      step;
      out_ready = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 10) begin step; n++; end
      vecs++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         errs++; $display("FAIL fclose_done: got done=%b valid=%b expected 1/0", done, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      do_reset;
      for (int i = 0; i < 6; i++) beat(32'h1111_1111);
      beat(32'h2121_2121);
      beat(32'h2121_2121);
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D6 || ovf_err !== 1'b0) begin
         errs++; $display("FAIL b2b_full: got valid=%b data=%h ovf=%b expected 1/%h/0", out_valid, out_data, ovf_err, D6);
      end
      res = 32'h2121_2121; res_valid = 1'b1; out_ready = 1'b1;
      step;
      res_valid = 1'b0; out_ready = 1'b0;
      vecs++;
      if (ovf_err !== 1'b0 || out_valid !== 1'b1 || out_data !== D6) begin
         errs++; $display("FAIL b2b_pushpop: got ovf=%b valid=%b data=%h expected 0/1/%h", ovf_err, out_valid, out_data, D6);
      end
      out_ready = 1'b1;
      step;
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D9) begin
         errs++; $display("FAIL b2b_third: got valid=%b data=%h expected 1/%h", out_valid, out_data, D9);
      end
      step;
      vecs++;
      if (out_valid !== 1'b0 || ovf_err !== 1'b0) begin
         errs++; $display("FAIL b2b_empty: got valid=%b ovf=%b expected 0/0", out_valid, ovf_err);
      end
   endtask

   task automatic test_mid_reset;
      do_reset;
      out_ready = 1'b1;
      beat(32'h1111_1111);
      beat(32'h1111_1111);
      rst = 1'b1;
      step;
      rst = 1'b0;
      vecs++;
      if ({out_valid, out_last, ovf_err, done, out_data} !== 40'd0) begin
         errs++; $display("FAIL midrst_outputs: got %h expected 0", {out_valid, out_last, ovf_err, done, out_data});
      end
      beat(32'h1111_1111);
      beat(32'h1111_1111);
      vecs++;
      if (out_valid !== 1'b0) begin
         errs++; $display("FAIL midrst_stale_cnt: got %b expected 0", out_valid);
      end
      beat(32'h1111_1111);
      vecs++;
      if (out_valid !== 1'b1 || out_data !== D6) begin
         errs++; $display("FAIL midrst_window: got valid=%b data=%h expected 1/%h", out_valid, out_data, D6);
      end
   endtask

   initial begin
      test_reset;
      test_single_window;
      test_saturation;
      test_overflow;
      test_flush_partial;
      test_finish_on_close;
      test_back_to_back;
      test_mid_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
